// File: rtl/dma_channel_arbiter_if.sv
// Device-side and controller-side signal bundle for dma_channel_arbiter.
// master = arbiter view, slave = peripherals plus dma_controller view.
interface dma_channel_arbiter_if #(
  parameter int NUM_CH   = 4,
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16
);
  logic [NUM_CH-1:0]              ch_rqst;
  logic [NUM_CH-1:0]              ch_rd_wr;
  logic [NUM_CH*ADD_LEN-1:0]      ch_num_words;
  logic [NUM_CH*(ADD_LEN+1)-1:0]  ch_start_addr;
  logic [NUM_CH-1:0]              ch_dev_ack;
  logic [NUM_CH*DATA_LEN-1:0]     ch_dev_in;
  logic [NUM_CH-1:0]              ch_grant;
  logic [NUM_CH-1:0]              ch_dma_ack;
  logic [NUM_CH-1:0]              ch_end_flag;
  logic [NUM_CH-1:0]              ch_err;
  logic [DATA_LEN-1:0]            dev_out;
  logic                           ctl_rqst;
  logic                           ctl_rd_wr;
  logic [ADD_LEN-1:0]             ctl_num_words;
  logic [ADD_LEN:0]               ctl_start_addr;
  logic                           ctl_dev_ack;
  logic [DATA_LEN-1:0]            ctl_dev_in;
  logic                           ctl_dma_ack;
  logic                           ctl_end_flag;
  logic [DATA_LEN-1:0]            ctl_dev_out;
  logic                           ctl_abort;

  modport master (
    input  ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    input  ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    output ch_grant, ch_dma_ack, ch_end_flag, ch_err, dev_out,
    output ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    output ctl_abort
  );

  modport slave (
    output ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    output ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    input  ch_grant, ch_dma_ack, ch_end_flag, ch_err, dev_out,
    input  ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    input  ctl_abort
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter sharing one dma_controller among NUM_CH devices, one whole transfer per grant.
// Optional BUSY-stall watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_channel_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int CH_BITS  = 2,
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_channel_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_BUSY    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int unsigned NCH = NUM_CH;

  if (NUM_CH < 2 || NUM_CH > 8 || (1 << CH_BITS) < NUM_CH || TIMEOUT < 1) begin : g_cfg_check
    $error("dma_channel_arbiter: unsupported parameter set");
  end

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [CH_BITS-1:0] grant_idx;
  logic [CH_BITS-1:0] last_idx;
  logic [CH_BITS-1:0] scan_idx;
  logic [CH_BITS-1:0] cand_idx;
  int unsigned        cand;
  logic               scan_hit;
  logic               owned;
  logic               timeout_hit;
  logic [NUM_CH-1:0]  grant_vec;

  logic [ADD_LEN-1:0]  nw_arr [NUM_CH];
  logic [ADD_LEN:0]    sa_arr [NUM_CH];
  logic [DATA_LEN-1:0] din_arr[NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign nw_arr[g]  = bus.ch_num_words[g*ADD_LEN +: ADD_LEN];
    assign sa_arr[g]  = bus.ch_start_addr[g*(ADD_LEN+1) +: (ADD_LEN+1)];
    assign din_arr[g] = bus.ch_dev_in[g*DATA_LEN +: DATA_LEN];
  end

  // Scan starts one past the previous owner so the last winner is considered last.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      cand     = ({{(32-CH_BITS){1'b0}}, last_idx} + off) % NCH;
      cand_idx = cand[CH_BITS-1:0];
      if (!scan_hit && bus.ch_rqst[cand_idx]) begin
        scan_hit = 1'b1;
        scan_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|bus.ch_rqst) state_nxt = S_ARB;
      S_ARB:     state_nxt = scan_hit ? S_REQ : S_IDLE;
      S_REQ:     state_nxt = bus.ctl_end_flag ? S_RELEASE : S_BUSY;
      S_BUSY:    if (bus.ctl_end_flag || timeout_hit) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      last_idx  <= CH_BITS'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      if (state == S_ARB && scan_hit) grant_idx <= scan_idx;
      if (state == S_RELEASE)         last_idx  <= grant_idx;
    end
  end

  assign owned = (state == S_REQ) || (state == S_BUSY);

  // Controller-facing fields come from the registered grant_idx so they cannot glitch mid-transfer.
  always_comb begin
    grant_vec          = '0;
    bus.ctl_rd_wr      = 1'b0;
    bus.ctl_num_words  = '0;
    bus.ctl_start_addr = '0;
    bus.ctl_dev_ack    = 1'b0;
    bus.ctl_dev_in     = '0;
    if (owned) begin
      grant_vec[grant_idx] = 1'b1;
      bus.ctl_rd_wr        = bus.ch_rd_wr[grant_idx];
      bus.ctl_num_words    = nw_arr[grant_idx];
      bus.ctl_start_addr   = sa_arr[grant_idx];
      bus.ctl_dev_ack      = bus.ch_dev_ack[grant_idx];
      bus.ctl_dev_in       = din_arr[grant_idx];
    end
  end

  assign bus.ctl_rqst    = (state == S_REQ);
  assign bus.ch_grant    = grant_vec;
  assign bus.ch_dma_ack  = grant_vec & {NUM_CH{bus.ctl_dma_ack}};
  assign bus.ch_end_flag = grant_vec & {NUM_CH{bus.ctl_end_flag}};
  assign bus.dev_out     = owned ? bus.ctl_dev_out : '0;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt;

  // A real end_flag in the same cycle as expiry wins: the transfer completed normally.
  assign timeout_hit = (state == S_BUSY) && (idle_cnt == CNT_W'(TIMEOUT)) && !bus.ctl_end_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (state != S_BUSY || bus.ctl_dma_ack || bus.ctl_dev_ack)
      idle_cnt <= '0;
    else if (idle_cnt != CNT_W'(TIMEOUT))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign bus.ctl_abort = timeout_hit;
  assign bus.ch_err    = grant_vec & {NUM_CH{timeout_hit}};
`else
  assign timeout_hit   = 1'b0;
  assign bus.ctl_abort = 1'b0;
  assign bus.ch_err    = '0;
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: table of arbitration rounds plus multi-cycle corner sequences.
module tb_dma_channel_arbiter;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   nw_tab[NCH];

  always #5 clk = ~clk;

  dma_channel_arbiter_if #(.NUM_CH(NCH), .ADD_LEN(16), .DATA_LEN(16)) bus ();

  dma_channel_arbiter #(
    .NUM_CH(NCH), .CH_BITS(2), .ADD_LEN(16), .DATA_LEN(16), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [NCH-1:0] rqst;
    int             exp_ch;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] exp_sa(input int ch);
    return 17'(32'h100 * (ch + 1));
  endfunction

  // Waits (bounded) for the ctl_rqst pulse, then checks owner and muxed fields.
  task automatic wait_req(input int ch, input int exp_lat);
    int n = 0;
    while (bus.ctl_rqst !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(bus.ctl_rqst), 32'd1);
    if (exp_lat > 0) check("req_latency", n, exp_lat);
    check("req_grant", 32'(bus.ch_grant), 32'(1 << ch));
    check("req_rd_wr", 32'(bus.ctl_rd_wr), 32'(ch % 2));
    check("req_num_words", 32'(bus.ctl_num_words), 32'(nw_tab[ch]));
    check("req_start_addr", 32'(bus.ctl_start_addr), 32'(exp_sa(ch)));
    check("req_dev_in", 32'(bus.ctl_dev_in), 32'h0000_A000 + 32'(ch));
  endtask

  // From REQ: move to BUSY, exercise routing, end the transfer, return to IDLE.
  task automatic finish_xfer(input int ch, input int nwords);
    tick();
    check("rqst_one_cycle", 32'(bus.ctl_rqst), 32'd0);
    check("busy_grant", 32'(bus.ch_grant), 32'(1 << ch));
    check("no_abort", 32'(bus.ctl_abort), 32'd0);
    bus.ch_dev_ack = ~(4'(1 << ch));
    #1 check("dev_ack_other", 32'(bus.ctl_dev_ack), 32'd0);
    bus.ch_dev_ack = 4'(1 << ch);
    #1 check("dev_ack_owner", 32'(bus.ctl_dev_ack), 32'd1);
    bus.ch_dev_ack = '0;
    for (int w = 0; w < nwords; w++) begin
      bus.ctl_dma_ack = 1'b1;
      bus.ctl_dev_out = 16'h5A00 + 16'(w);
      #1 check("dma_ack_route", 32'(bus.ch_dma_ack), 32'(1 << ch));
      check("dev_out", 32'(bus.dev_out), 32'h5A00 + 32'(w));
      tick();
      bus.ctl_dma_ack = 1'b0;
      tick();
    end
    bus.ctl_end_flag = 1'b1;
    #1 check("end_route", 32'(bus.ch_end_flag), 32'(1 << ch));
    tick();
    bus.ctl_end_flag = 1'b0;
    check("release_grant", 32'(bus.ch_grant), 32'd0);
    check("release_num_words", 32'(bus.ctl_num_words), 32'd0);
    check("release_dev_out", 32'(bus.dev_out), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 0};
    vecs[1]  = '{4'b1111, 1};
    vecs[2]  = '{4'b1111, 2};
    vecs[3]  = '{4'b1111, 3};
    vecs[4]  = '{4'b1111, 0};
    vecs[5]  = '{4'b0101, 2};
    vecs[6]  = '{4'b0101, 0};
    vecs[7]  = '{4'b1000, 3};
    vecs[8]  = '{4'b1001, 0};
    vecs[9]  = '{4'b1001, 3};
    vecs[10] = '{4'b0110, 1};

    reset            = 1'b1;
    bus.ch_rqst      = '0;
    bus.ch_dev_ack   = '0;
    bus.ctl_dma_ack  = 1'b0;
    bus.ctl_end_flag = 1'b0;
    bus.ctl_dev_out  = 16'hDEAD;
    for (int i = 0; i < NCH; i++) begin
      nw_tab[i] = i + 1;
      bus.ch_rd_wr[i] = (i % 2) == 1;
      bus.ch_start_addr[i*17 +: 17] = exp_sa(i);
      bus.ch_dev_in[i*16 +: 16] = 16'hA000 + 16'(i);
    end
    nw_tab[1] = 4;
    for (int i = 0; i < NCH; i++) bus.ch_num_words[i*16 +: 16] = 16'(nw_tab[i]);

    tick();
    tick();
    check("rst_grant", 32'(bus.ch_grant), 32'd0);
    check("rst_ctl_rqst", 32'(bus.ctl_rqst), 32'd0);
    check("rst_dev_out", 32'(bus.dev_out), 32'd0);
    check("rst_abort", 32'(bus.ctl_abort), 32'd0);
    reset = 1'b0;
    tick();

    // Single read transfer on ch1, 4 words at 0x0200.
    bus.ch_rqst = 4'b0010;
    wait_req(1, 2);
    check("t1_start_addr", 32'(bus.ctl_start_addr), 32'h0200);
    bus.ch_rqst = '0;
    finish_xfer(1, 4);

    // Round-robin table; reset first so ch0 wins the first round.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int v = 0; v < 11; v++) begin
      bus.ch_rqst = vecs[v].rqst;
      wait_req(vecs[v].exp_ch, 2);
      finish_xfer(vecs[v].exp_ch, 1);
    end
    bus.ch_rqst = '0;
    tick();

    // ch2 arrives while ch0 is BUSY: ch0 fields hold, ch2 follows with 4-cycle turnaround.
    bus.ch_rqst = 4'b0001;
    wait_req(0, 2);
    tick();
    bus.ch_rqst = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_grant", 32'(bus.ch_grant), 32'd1);
      check("t3_hold_addr", 32'(bus.ctl_start_addr), 32'(exp_sa(0)));
    end
    bus.ctl_end_flag = 1'b1;
    tick();
    bus.ctl_end_flag = 1'b0;
    wait_req(2, 3);
    bus.ch_rqst = '0;
    finish_xfer(2, 1);

    // Zero-length transfer on ch3: end_flag already in REQ.
    nw_tab[3] = 0;
    bus.ch_num_words[3*16 +: 16] = '0;
    bus.ch_rqst = 4'b1000;
    wait_req(3, 2);
    bus.ch_rqst = '0;
    bus.ctl_end_flag = 1'b1;
    #1 check("t4_end_route", 32'(bus.ch_end_flag), 32'b1000);
    tick();
    bus.ctl_end_flag = 1'b0;
    check("t4_release_grant", 32'(bus.ch_grant), 32'd0);
    tick();
    tick();
    check("t4_idle_rqst", 32'(bus.ctl_rqst), 32'd0);
    check("t4_idle_grant", 32'(bus.ch_grant), 32'd0);

    // Reset in BUSY clears outputs asynchronously; ch0 wins afterwards.
    bus.ch_rqst = 4'b0010;
    wait_req(1, 2);
    bus.ch_rqst = '0;
    tick();
    bus.ctl_dma_ack = 1'b1;
    bus.ctl_dev_out = 16'h1234;
    #1 check("t5_pre_ack", 32'(bus.ch_dma_ack), 32'b0010);
    reset = 1'b1;
    #1;
    check("t5_rst_grant", 32'(bus.ch_grant), 32'd0);
    check("t5_rst_ack", 32'(bus.ch_dma_ack), 32'd0);
    check("t5_rst_dev_out", 32'(bus.dev_out), 32'd0);
    check("t5_rst_addr", 32'(bus.ctl_start_addr), 32'd0);
    bus.ctl_dma_ack = 1'b0;
    tick();
    reset = 1'b0;
    bus.ch_rqst = 4'b1111;
    wait_req(0, 2);
    bus.ch_rqst = '0;
    finish_xfer(0, 1);

`ifdef DMA_ARB_TIMEOUT_EN
    // Device never acks a write on ch0: abort 16 BUSY cycles in, then ch0 loses priority.
    begin
      int n = 0;
      bus.ch_rqst = 4'b0001;
      wait_req(0, 2);
      bus.ch_rqst = '0;
      tick();
      while (bus.ctl_abort !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("t6_abort_seen", 32'(bus.ctl_abort), 32'd1);
      check("t6_abort_time", n, 16);
      check("t6_err", 32'(bus.ch_err), 32'b0001);
      tick();
      check("t6_abort_pulse", 32'(bus.ctl_abort), 32'd0);
      check("t6_release_grant", 32'(bus.ch_grant), 32'd0);
      tick();
      bus.ch_rqst = 4'b0011;
      wait_req(1, 2);
      bus.ch_rqst = '0;
      finish_xfer(1, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
